// File: rtl/sig_chn_sched.sv
// Multi-channel frame scheduler: emits frames of frm_len beats on a rotating set of channels,
// separated by gap_len idle cycles. Optional frame counter enabled by SIG_CHN_SCHED_FRM_CNT_EN.
module sig_chn_sched #(
    parameter int G_LEN_W = 16,
    parameter int G_CNT_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [G_LEN_W-1:0] i_frm_len,
    input  logic [G_LEN_W-1:0] i_gap_len,
    input  logic [3:0]         i_chn_mask,
    input  logic               i_rdy,
    output logic               o_vld,
    output logic               o_tlast,
    output logic [1:0]         o_dat_chn,
    output logic               o_busy,
    output logic [G_CNT_W-1:0] o_frm_cnt
);

    localparam logic [G_LEN_W-1:0] LEN_ONE = {{(G_LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

    state_t             state_q;
    logic [G_LEN_W-1:0] len_q;
    logic [G_LEN_W-1:0] gap_q;
    logic [G_LEN_W-1:0] beat_q;
    logic [G_LEN_W-1:0] gap_cnt_q;
    logic [3:0]         mask_q;
    logic [1:0]         chn_q;
    logic               vld_q;
    logic               tlast_q;
    logic               stop_q;

    function automatic logic [1:0] lowest_chn(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Scan downward over offsets so the smallest offset from cur+1 wins; offset 4 (cur itself) is the fallback.
    function automatic logic [1:0] next_chn(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] idx;
        r = cur;
        for (int i = 3; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            gap_q     <= '0;
            beat_q    <= '0;
            gap_cnt_q <= '0;
            mask_q    <= '0;
            chn_q     <= '0;
            vld_q     <= 1'b0;
            tlast_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start && !i_stop && (i_chn_mask != 4'b0) && (i_frm_len != '0)) begin
                        state_q <= ST_RUN;
                        len_q   <= i_frm_len;
                        gap_q   <= i_gap_len;
                        mask_q  <= i_chn_mask;
                        chn_q   <= lowest_chn(i_chn_mask);
                        beat_q  <= '0;
                        vld_q   <= 1'b1;
                        tlast_q <= (i_frm_len == LEN_ONE);
                    end
                end
                ST_RUN: begin
                    if (i_stop) stop_q <= 1'b1;
                    if (i_rdy) begin
                        if (tlast_q) begin
                            beat_q    <= '0;
                            gap_cnt_q <= '0;
                            // A stop arriving together with the last beat also ends the run here.
                            if (stop_q || i_stop) begin
                                state_q <= ST_IDLE;
                                vld_q   <= 1'b0;
                                tlast_q <= 1'b0;
                                stop_q  <= 1'b0;
                            end else if (gap_q != '0) begin
                                state_q <= ST_GAP;
                                vld_q   <= 1'b0;
                                tlast_q <= 1'b0;
                            end else begin
                                chn_q   <= next_chn(chn_q, mask_q);
                                tlast_q <= (len_q == LEN_ONE);
                            end
                        end else begin
                            beat_q  <= beat_q + LEN_ONE;
                            tlast_q <= ((beat_q + LEN_ONE) == (len_q - LEN_ONE));
                        end
                    end
                end
                ST_GAP: begin
                    if (i_stop) begin
                        state_q   <= ST_IDLE;
                        gap_cnt_q <= '0;
                        stop_q    <= 1'b0;
                    end else if (gap_cnt_q == (gap_q - LEN_ONE)) begin
                        state_q   <= ST_RUN;
                        gap_cnt_q <= '0;
                        beat_q    <= '0;
                        chn_q     <= next_chn(chn_q, mask_q);
                        vld_q     <= 1'b1;
                        tlast_q   <= (len_q == LEN_ONE);
                    end else begin
                        gap_cnt_q <= gap_cnt_q + LEN_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SIG_CHN_SCHED_FRM_CNT_EN
    logic [G_CNT_W-1:0] frm_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frm_cnt_q <= '0;
        end else if (vld_q && i_rdy && tlast_q) begin
            frm_cnt_q <= frm_cnt_q + {{(G_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_frm_cnt = frm_cnt_q;
`else
    assign o_frm_cnt = '0;
`endif

    assign o_vld     = vld_q;
    assign o_tlast   = tlast_q;
    assign o_dat_chn = chn_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: doc/sig_chn_sched.md
SIG_CHN_SCHED -- requirements
Module: sig_chn_sched

Interface
REQ-001 SHALL have parameter G_LEN_W, default 16, width of frame-length and gap-length fields.
REQ-002 SHALL have parameter G_CNT_W, default 32, width of completed-frame counter.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  single-cycle pulse, start scheduling.
REQ-006 SHALL have port i_stop  input  1  single-cycle pulse, request graceful stop.
REQ-007 SHALL have port i_frm_len  input  G_LEN_W  beats per frame, must be nonzero.
REQ-008 SHALL have port i_gap_len  input  G_LEN_W  idle cycles between frames.
REQ-009 SHALL have port i_chn_mask  input  4  enabled channels, bit n = channel n.
REQ-010 SHALL have port i_rdy  input  1  downstream tready.
REQ-011 SHALL have port o_vld  output  1  beat valid (tvalid).
REQ-012 SHALL have port o_tlast  output  1  last beat of frame.
REQ-013 SHALL have port o_dat_chn  output  2  channel of current frame.
REQ-014 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port o_frm_cnt  output  G_CNT_W  completed-frame count.

Function
REQ-016 SHALL implement states IDLE, RUN, GAP.
REQ-017 In IDLE: i_start with i_chn_mask!=0 and i_frm_len!=0 SHALL latch frm_len, gap_len and mask, select the lowest set mask bit, and enter RUN the next cycle.
REQ-018 In IDLE: i_start with zero mask or zero frm_len SHALL be ignored.
REQ-019 In IDLE: simultaneous i_start and i_stop SHALL leave the block in IDLE.
REQ-020 In RUN: o_vld SHALL be 1; a beat is accepted when o_vld & i_rdy; o_vld, o_tlast and o_dat_chn SHALL stay stable while i_rdy=0.
REQ-021 In RUN: o_tlast SHALL be 1 exactly on beat index frm_len-1 (0-based); frm_len=1 asserts o_tlast on the first beat.
REQ-022 On the accepted last beat, the block SHALL go to IDLE if stop is pending.
REQ-023 On the accepted last beat with no stop pending, the block SHALL go to GAP if gap_len!=0, else to RUN on the next channel with no bubble cycle.
REQ-024 In GAP: o_vld SHALL be 0 for exactly gap_len cycles, then the block SHALL enter RUN on the next channel.
REQ-025 The next channel SHALL be the first set bit of the latched mask searching upward from current+1, wrapping 3->0; with a single mask bit the channel is unchanged.
REQ-026 i_stop in RUN SHALL set stop-pending; the current frame SHALL complete in full.
REQ-027 i_stop in GAP SHALL go to IDLE the next cycle.
REQ-028 Stop-pending SHALL clear on entry to IDLE.
REQ-029 i_start while busy SHALL be ignored.
REQ-030 Config inputs SHALL only be sampled at an accepted start; changes while busy SHALL have no effect.
REQ-031 Beat and gap counters SHALL be G_LEN_W wide and SHALL reset to 0 on each frame or gap entry.

Reset
REQ-032 i_rst SHALL dominate all other inputs in the same cycle.
REQ-033 i_rst, including mid-frame, SHALL force IDLE with o_vld=0, o_tlast=0, o_dat_chn=0, o_busy=0, o_frm_cnt=0, stop-pending=0, counters=0; a truncated frame receives no o_tlast.

Configuration
REQ-034 Macro SIG_CHN_SCHED_FRM_CNT_EN SHALL select the frame-counter feature.
REQ-035 With SIG_CHN_SCHED_FRM_CNT_EN defined, o_frm_cnt SHALL increment by 1 on every accepted o_tlast beat and wrap from all-ones to 0.
REQ-036 Without SIG_CHN_SCHED_FRM_CNT_EN, o_frm_cnt SHALL be constant 0 and no counter register SHALL be inferred.

Verification
REQ-037 Bench SHALL cover: mask=4'b1011, frm_len=3, gap=2, i_rdy=1 -> channel sequence 0,1,3,0; each frame 3 beats with o_tlast on beat 3; 2 idle cycles between frames.
REQ-038 Bench SHALL cover: gap=0, mask=4'b0110, frm_len=2 -> back-to-back frames on channels 1,2,1 with o_vld continuous.
REQ-039 Bench SHALL cover: i_rdy toggling randomly, frm_len=4 -> exactly 4 accepted beats per frame; outputs stable while i_rdy=0.
REQ-040 Bench SHALL cover: i_stop on beat 2 of 5 -> beats 3-5 still issued with o_tlast on beat 5, then o_busy=0 the next cycle.
REQ-041 Bench SHALL cover: i_rst mid-frame (beat 2 of 4) -> all outputs 0 the next cycle; a fresh i_start restarts at the lowest mask channel.
REQ-042 Bench SHALL cover: i_start with mask=0, and i_start with frm_len=0 -> o_busy stays 0; with the macro defined, 10 frames -> o_frm_cnt=10.
